avalon_sdram_arbiter: RTL and testbench
=======================================

Name: avalon_sdram_arbiter

Overview:
- Two-master round-robin arbiter that shares the single Avalon-MM slave port of avalon_sdram_controller.
- Typical masters: m0 = CPU/data bus, m1 = display/DMA.
- Forwards one single-beat command per cycle to the slave.
- Records the issuing master of every accepted read in an in-order tag FIFO, and routes each returning readdatavalid beat back to that master.

Parameters:
AW, 24, Avalon word-address width (matches controller AVS_AW)
DW, 16, Avalon data width (matches AVS_DW)
BYTE, 2, byteenable width (DW/8)
TAG_DEPTH, 8, max outstanding reads across both masters; power of 2, >=2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (0 = reset)
m0_read / m1_read  in  1  read request
m0_write / m1_write  in  1  write request (read&write together is illegal; write wins)
m0_address / m1_address  in  AW  word address
m0_writedata / m1_writedata  in  DW  write data
m0_byteenable / m1_byteenable  in  BYTE  byte enables
m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle
m0_readdata / m1_readdata  out  DW  read data (shared s_readdata)
m0_readdatavalid / m1_readdatavalid  out  1  read beat for this master
s_read, s_write  out  1  to controller avs_read/avs_write
s_address  out  AW  to controller
s_writedata  out  DW  to controller
s_byteenable  out  BYTE  to controller
s_waitrequest  in  1  from controller
s_readdata  in  DW  from controller
s_readdatavalid  in  1  from controller
rd_outstanding  out  log2(TAG_DEPTH)+1  current tag-FIFO occupancy
err_unexp_rdv  out  1  sticky: s_readdatavalid arrived with tag FIFO empty

Behaviour:
- Reset (reset==0 at posedge):
  - Tag FIFO empty, rd_outstanding=0, err_unexp_rdv=0.
  - Priority pointer = m0 (m0 wins the first tie).
  - All m*_readdatavalid=0.
  - Reset mid-operation discards all outstanding tags. Later s_readdatavalid beats set err_unexp_rdv and are not forwarded.
- Request definitions:
  - req_i = mi_read|mi_write.
  - A read is blocked when the tag FIFO is full.
  - A write is never blocked by the tag FIFO.
- Arbitration (combinational, same cycle):
  - eligible_i = req_i & ~(read-only request & tag_full).
  - If only one master is eligible, it is granted.
  - If both are eligible, the master named by the priority pointer is granted.
  - No eligible master: s_read=s_write=0; s_address/writedata/byteenable = m0 values (don't-care).
- Slave drive: s_* driven from the granted master's signals, with s_read = granted read & ~granted write.
- Waitrequest:
  - Granted master: mi_waitrequest = s_waitrequest.
  - Non-granted master: mi_waitrequest = 1.
  - Master with no request: mi_waitrequest = 1.
  - Waitrequest is always 1 while reset==0.
- Transfer and pointer update:
  - Transfer = (s_read|s_write) & ~s_waitrequest.
  - On transfer, the priority pointer moves to the non-granted master. The pointer is held otherwise.
  - A stalled grant may be re-arbitrated next cycle; masters must hold their request until waitrequest=0 (Avalon rule).
- Tag FIFO:
  - 1-bit entries, in order.
  - Push (granted id) on a read transfer.
  - Pop on s_readdatavalid.
  - Simultaneous push and pop is legal at any occupancy, including full (pop frees the slot the same cycle, so full does not gate the push when pop=1).
  - Pointers wrap modulo TAG_DEPTH.
  - rd_outstanding is updated as occ + push - pop.
- Read return:
  - mi_readdatavalid = s_readdatavalid & (tag head == i) & ~empty. Combinational, zero added latency.
  - m0_readdata = m1_readdata = s_readdata.
  - s_readdatavalid while the FIFO is empty: no master valid; err_unexp_rdv is set and held until reset.
- Ordering: return order equals acceptance order. The controller is in-order, so no reordering is needed.
- Write-only traffic never touches the tag FIFO.

Test Plan:
- Reset held low 3 cycles with m0_read=1 -> m0_waitrequest=1, s_read=0, rd_outstanding=0. After release, m0 read to 0x000010 issues on the first cycle and rd_outstanding=1.
- m0 and m1 both write continuously, s_waitrequest=0 -> grants alternate m0,m1,m0,m1; s_address alternates between the m0 and m1 addresses on successive cycles; exactly 1 transfer per cycle.
- m0 reads 0x100, m1 reads 0x200, m0 reads 0x300; readdatavalid returned with data 0xAAAA, 0xBBBB, 0xCCCC -> m0 gets 0xAAAA, m1 gets 0xBBBB, m0 gets 0xCCCC; the other master's valid stays 0.
- TAG_DEPTH=8, m1 issues 8 reads with no returns -> 9th read sees m1_waitrequest=1 while m0 writes still pass. One s_readdatavalid then lets the read issue the same cycle; rd_outstanding stays 8.
- s_waitrequest=1 for 5 cycles with m0 requesting -> m0_waitrequest=1, pointer unchanged. When it drops, m0 transfers once and the pointer moves to m1.
- s_readdatavalid pulsed with no outstanding reads -> both m*_readdatavalid=0 and err_unexp_rdv=1 sticky; cleared only by reset=0.

Source files
------------

// File: rtl/avalon_sdram_arbiter.sv
// Two-master round-robin arbiter in front of the single Avalon-MM slave port
// of the SDRAM controller. Reads are tagged with their issuing master in an
// in-order FIFO so that returning readdatavalid beats are routed back.
module avalon_sdram_arbiter #(
  parameter int AW        = 24,
  parameter int DW        = 16,
  parameter int BYTE      = 2,
  parameter int TAG_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic                         m0_read,
  input  logic                         m0_write,
  input  logic [AW-1:0]                m0_address,
  input  logic [DW-1:0]                m0_writedata,
  input  logic [BYTE-1:0]              m0_byteenable,
  output logic                         m0_waitrequest,
  output logic [DW-1:0]                m0_readdata,
  output logic                         m0_readdatavalid,

  input  logic                         m1_read,
  input  logic                         m1_write,
  input  logic [AW-1:0]                m1_address,
  input  logic [DW-1:0]                m1_writedata,
  input  logic [BYTE-1:0]              m1_byteenable,
  output logic                         m1_waitrequest,
  output logic [DW-1:0]                m1_readdata,
  output logic                         m1_readdatavalid,

  output logic                         s_read,
  output logic                         s_write,
  output logic [AW-1:0]                s_address,
  output logic [DW-1:0]                s_writedata,
  output logic [BYTE-1:0]              s_byteenable,
  input  logic                         s_waitrequest,
  input  logic [DW-1:0]                s_readdata,
  input  logic                         s_readdatavalid,

  output logic [$clog2(TAG_DEPTH):0]   rd_outstanding,
  output logic                         err_unexp_rdv
);

  localparam int TW = $clog2(TAG_DEPTH);
  localparam logic [TW:0] FULL_CNT = (TW+1)'(TAG_DEPTH);

  // priority pointer: 0 = m0 wins a tie, 1 = m1 wins a tie
  logic                 ptr_q, ptr_d;
  logic [TAG_DEPTH-1:0] tag_q, tag_d;
  logic [TW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [TW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [TW:0]          occ_q, occ_d;
  logic                 err_q, err_d;

  logic tag_empty, tag_full, pop, push, rd_block;
  logic elig0, elig1, any_elig, gnt1;
  logic g_read, g_write, xfer;

  // FIFO status; a same-cycle pop frees a slot, so a full FIFO only blocks
  // reads when no beat is returning
  always_comb begin
    tag_empty = (occ_q == '0);
    tag_full  = (occ_q == FULL_CNT);
    pop       = reset & s_readdatavalid & ~tag_empty;
    rd_block  = tag_full & ~pop;
  end

  // eligibility and round-robin grant selection
  always_comb begin
    elig0    = reset & (m0_read | m0_write) & ~(m0_read & ~m0_write & rd_block);
    elig1    = reset & (m1_read | m1_write) & ~(m1_read & ~m1_write & rd_block);
    any_elig = elig0 | elig1;
    gnt1     = elig1 & (~elig0 | ptr_q);
  end

  // slave-side command mux; idle cycles park the payload on m0
  always_comb begin
    g_read       = gnt1 ? m1_read       : m0_read;
    g_write      = gnt1 ? m1_write      : m0_write;
    s_address    = gnt1 ? m1_address    : m0_address;
    s_writedata  = gnt1 ? m1_writedata  : m0_writedata;
    s_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
    s_write      = any_elig & g_write;
    s_read       = any_elig & g_read & ~g_write;
    xfer         = (s_read | s_write) & ~s_waitrequest;
    push         = xfer & s_read;
  end

  // master-side handshake and read-return routing
  always_comb begin
    m0_waitrequest   = (any_elig & ~gnt1) ? s_waitrequest : 1'b1;
    m1_waitrequest   = (any_elig &  gnt1) ? s_waitrequest : 1'b1;
    m0_readdatavalid = pop & ~tag_q[rd_ptr_q];
    m1_readdatavalid = pop &  tag_q[rd_ptr_q];
    m0_readdata      = s_readdata;
    m1_readdata      = s_readdata;
    rd_outstanding   = occ_q;
    err_unexp_rdv    = err_q;
  end

  // next state for pointer, tag FIFO and sticky error
  always_comb begin
    ptr_d    = xfer ? ~gnt1 : ptr_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      tag_d[wr_ptr_q] = gnt1;
      wr_ptr_d        = wr_ptr_q + TW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + TW'(1);
    end
    occ_d = occ_q + (TW+1)'(push) - (TW+1)'(pop);
    err_d = err_q | (s_readdatavalid & tag_empty);
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q    <= 1'b0;
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_avalon_sdram_arbiter.sv
module tb_avalon_sdram_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int BYTE = 2;
  localparam int TAG_DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  logic m0_read, m0_write, m1_read, m1_write;
  logic [AW-1:0] m0_address, m1_address;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic [BYTE-1:0] m0_byteenable, m1_byteenable;
  logic m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic m0_readdatavalid, m1_readdatavalid;
  logic s_read, s_write;
  logic [AW-1:0] s_address;
  logic [DW-1:0] s_writedata;
  logic [BYTE-1:0] s_byteenable;
  logic s_waitrequest;
  logic [DW-1:0] s_readdata;
  logic s_readdatavalid;
  logic [$clog2(TAG_DEPTH):0] rd_outstanding;
  logic err_unexp_rdv;

  always #5 clk = ~clk;

  avalon_sdram_arbiter #(.AW(AW), .DW(DW), .BYTE(BYTE), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_read(s_read), .s_write(s_write), .s_address(s_address),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .rd_outstanding(rd_outstanding), .err_unexp_rdv(err_unexp_rdv)
  );

  typedef struct {
    logic          id;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } xfer_t;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
  } ret_t;

  xfer_t xq[$];
  ret_t  rq[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic exp_x(input logic id, input logic rd, input logic wr,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data);
    xfer_t e;
    e.id = id; e.rd = rd; e.wr = wr; e.addr = addr; e.data = data;
    xq.push_back(e);
  endtask

  task automatic exp_r(input logic id, input logic [DW-1:0] data);
    ret_t e;
    e.id = id; e.data = data;
    rq.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // monitor: compares every accepted slave command and every returned beat
  always @(negedge clk) begin
    if (reset === 1'b1 && (s_read || s_write) && !s_waitrequest) begin
      if (xq.size() == 0) begin
        check("xfer_unexpected", 64'd1, 64'd0);
      end else begin
        xfer_t e;
        logic gid;
        e = xq.pop_front();
        gid = m0_waitrequest ? 1'b1 : 1'b0;
        check("xfer", {21'd0, gid, s_read, s_write, s_address, (s_write ? s_writedata : 16'h0)},
                      {21'd0, e.id, e.rd, e.wr, e.addr, (e.wr ? e.data : 16'h0)});
      end
    end
    if (m0_readdatavalid || m1_readdatavalid) begin
      if (rq.size() == 0) begin
        check("rdv_unexpected", {62'd0, m1_readdatavalid, m0_readdatavalid}, 64'd0);
      end else begin
        ret_t r;
        r = rq.pop_front();
        check("rdv", {30'd0, m1_readdatavalid, m0_readdatavalid, m0_readdata, m1_readdata},
                     {30'd0, r.id, ~r.id, r.data, r.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    m0_read = 1'b1; m0_write = 1'b0; m0_address = 24'h000010;
    m0_writedata = '0; m0_byteenable = 2'b11;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = '0;
    m1_writedata = '0; m1_byteenable = 2'b11;
    s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;

    // reset held with a pending read
    repeat (3) begin
      cyc();
      @(negedge clk);
      check("rst_m0_wait", {63'd0, m0_waitrequest}, 64'd1);
      check("rst_s_read", {63'd0, s_read}, 64'd0);
      check("rst_outstanding", {60'd0, rd_outstanding}, 64'd0);
    end
    cyc();
    reset = 1'b1;
    exp_x(1'b0, 1'b1, 1'b0, 24'h000010, 16'h0);
    cyc();
    m0_read = 1'b0;
    @(negedge clk);
    check("first_rd_outstanding", {60'd0, rd_outstanding}, 64'd1);
    cyc();
    s_readdatavalid = 1'b1; s_readdata = 16'h1234;
    exp_r(1'b0, 16'h1234);
    cyc();
    s_readdatavalid = 1'b0;
    @(negedge clk);
    check("drain_outstanding", {60'd0, rd_outstanding}, 64'd0);

    // both masters write continuously; pointer currently favours m1
    cyc();
    m0_write = 1'b1; m0_address = 24'h0000A0; m0_writedata = 16'h0A0A;
    m1_write = 1'b1; m1_address = 24'h0000B0; m1_writedata = 16'h0B0B;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) exp_x(1'b1, 1'b0, 1'b1, 24'h0000B0, 16'h0B0B);
      else            exp_x(1'b0, 1'b0, 1'b1, 24'h0000A0, 16'h0A0A);
      cyc();
    end
    m0_write = 1'b0; m1_write = 1'b0;

    // three interleaved reads, returned in order
    m0_read = 1'b1; m0_address = 24'h000100;
    exp_x(1'b0, 1'b1, 1'b0, 24'h000100, 16'h0);
    cyc();
    m0_read = 1'b0; m1_read = 1'b1; m1_address = 24'h000200;
    exp_x(1'b1, 1'b1, 1'b0, 24'h000200, 16'h0);
    cyc();
    m1_read = 1'b0; m0_read = 1'b1; m0_address = 24'h000300;
    exp_x(1'b0, 1'b1, 1'b0, 24'h000300, 16'h0);
    cyc();
    m0_read = 1'b0;
    @(negedge clk);
    check("three_outstanding", {60'd0, rd_outstanding}, 64'd3);
    cyc();
    s_readdatavalid = 1'b1; s_readdata = 16'hAAAA; exp_r(1'b0, 16'hAAAA);
    cyc();
    s_readdata = 16'hBBBB; exp_r(1'b1, 16'hBBBB);
    cyc();
    s_readdata = 16'hCCCC; exp_r(1'b0, 16'hCCCC);
    cyc();
    s_readdatavalid = 1'b0;

    // fill the tag FIFO from m1
    for (int i = 0; i < TAG_DEPTH; i++) begin
      m1_read = 1'b1; m1_address = 24'h000400 + 24'(i);
      exp_x(1'b1, 1'b1, 1'b0, 24'h000400 + 24'(i), 16'h0);
      cyc();
    end
    m1_read = 1'b0;
    @(negedge clk);
    check("full_outstanding", {60'd0, rd_outstanding}, 64'd8);
    cyc();
    m1_read = 1'b1; m1_address = 24'h000500;
    m0_write = 1'b1; m0_address = 24'h000600; m0_writedata = 16'h6060;
    exp_x(1'b0, 1'b0, 1'b1, 24'h000600, 16'h6060);
    @(negedge clk);
    check("full_m1_blocked", {63'd0, m1_waitrequest}, 64'd1);
    cyc();
    m0_write = 1'b0;
    s_readdatavalid = 1'b1; s_readdata = 16'h1111;
    exp_r(1'b1, 16'h1111);
    exp_x(1'b1, 1'b1, 1'b0, 24'h000500, 16'h0);
    cyc();
    m1_read = 1'b0; s_readdatavalid = 1'b0;
    @(negedge clk);
    check("full_pushpop_outstanding", {60'd0, rd_outstanding}, 64'd8);
    cyc();
    s_readdatavalid = 1'b1;
    for (int i = 0; i < TAG_DEPTH; i++) begin
      s_readdata = 16'h2000 + 16'(i);
      exp_r(1'b1, 16'h2000 + 16'(i));
      cyc();
    end
    s_readdatavalid = 1'b0;
    @(negedge clk);
    check("full_drained", {60'd0, rd_outstanding}, 64'd0);

    // slave stall; pointer must hold at m0
    cyc();
    s_waitrequest = 1'b1;
    m0_write = 1'b1; m0_address = 24'h000800; m0_writedata = 16'h5555;
    repeat (5) begin
      @(negedge clk);
      check("stall_m0_wait", {62'd0, m0_waitrequest, m1_waitrequest}, 64'd3);
      cyc();
    end
    s_waitrequest = 1'b0;
    m1_write = 1'b1; m1_address = 24'h000900; m1_writedata = 16'h6666;
    exp_x(1'b0, 1'b0, 1'b1, 24'h000800, 16'h5555);
    cyc();
    exp_x(1'b1, 1'b0, 1'b1, 24'h000900, 16'h6666);
    cyc();
    m0_write = 1'b0; m1_write = 1'b0;

    // unexpected readdatavalid with empty FIFO
    s_readdatavalid = 1'b1; s_readdata = 16'hDEAD;
    @(negedge clk);
    check("unexp_no_valid", {62'd0, m1_readdatavalid, m0_readdatavalid}, 64'd0);
    cyc();
    s_readdatavalid = 1'b0;
    @(negedge clk);
    check("unexp_err_set", {63'd0, err_unexp_rdv}, 64'd1);
    repeat (3) cyc();
    @(negedge clk);
    check("unexp_err_sticky", {63'd0, err_unexp_rdv}, 64'd1);
    cyc();
    reset = 1'b0;
    cyc();
    @(negedge clk);
    check("unexp_err_cleared", {63'd0, err_unexp_rdv}, 64'd0);
    cyc();
    reset = 1'b1;

    // reset with a read outstanding discards its tag
    m1_read = 1'b1; m1_address = 24'h000700;
    exp_x(1'b1, 1'b1, 1'b0, 24'h000700, 16'h0);
    cyc();
    m1_read = 1'b0;
    @(negedge clk);
    check("midrst_outstanding", {60'd0, rd_outstanding}, 64'd1);
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    @(negedge clk);
    check("midrst_cleared", {60'd0, rd_outstanding}, 64'd0);
    cyc();
    s_readdatavalid = 1'b1; s_readdata = 16'hBEEF;
    @(negedge clk);
    check("midrst_no_valid", {62'd0, m1_readdatavalid, m0_readdatavalid}, 64'd0);
    cyc();
    s_readdatavalid = 1'b0;
    @(negedge clk);
    check("midrst_err", {63'd0, err_unexp_rdv}, 64'd1);

    repeat (2) cyc();
    check("xfer_queue_empty", 64'(xq.size()), 64'd0);
    check("rdv_queue_empty", 64'(rq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
